fft_bitrev_reader: RTL and testbench

//   Output-side reader for the 16-point radix-2 FFT. Accepts the last butterfly stage's complex results
//   in bit-reversed bin order, one per cycle, and re-emits them in natural bin order (0..N-1).

---
 rtl/fft_bitrev_reader_if.sv | 29 ++
 rtl/fft_bitrev_reader.sv | 136 +++++++++++++
 tb/tb_fft_bitrev_reader.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_reader_if.sv
// Stream bundle for the FFT bit-reverse reader: bit-reversed samples in, natural-order samples out.
// The master side is the producer/consumer pair around the reader; the slave side is the reader.
interface fft_bitrev_reader_if #(
  parameter int NBITS = 16,
  parameter int LOG2N = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [NBITS-1:0] in_re;
  logic signed [NBITS-1:0] in_im;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [NBITS-1:0] out_re;
  logic signed [NBITS-1:0] out_im;
  logic [LOG2N-1:0]        out_index;
  logic                    out_last;
  logic                    frame_err;

  modport master (
    output in_valid, in_re, in_im, in_last, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_index, out_last, frame_err
  );

  modport slave (
    input  in_valid, in_re, in_im, in_last, out_ready,
    output in_ready, out_valid, out_re, out_im, out_index, out_last, frame_err
  );
endinterface

// File: rtl/fft_bitrev_reader.sv
// Ping-pong reorder buffer: writes bit-reversed FFT output into one bank while the other
// drains in natural bin order, sustaining one sample per cycle on both sides.

// One bank of the ping-pong buffer: RAM plus its EMPTY/FILLING/FULL occupancy state.
module fft_bitrev_bank #(
  parameter int DW    = 32,
  parameter int LOG2N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_close,
  input  logic [LOG2N-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_close,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [DW-1:0]    rd_data,
  output logic             full
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;

  bank_st_t      st;
  logic [DW-1:0] mem [2**LOG2N];

  // Reader and writer never own the same bank in one cycle, so the two events are exclusive here.
  always_ff @(posedge clk) begin
    if (!rst_n)        st <= EMPTY;
    else if (wr_en)    st <= wr_close ? FULL : FILLING;
    else if (rd_close) st <= EMPTY;
  end

  // Contents survive reset; occupancy state alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
  assign full    = (st == FULL);
endmodule

module fft_bitrev_reader #(
  parameter int NBITS   = 16,
  parameter int NPOINTS = 16,
  parameter int LOG2N   = 4
) (
  input logic           clk,
  input logic           rst_n,
  fft_bitrev_reader_if.slave bus
);
  localparam int               NBANKS   = 2;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(NPOINTS - 1);

  typedef struct packed {
    logic signed [NBITS-1:0] re;
    logic signed [NBITS-1:0] im;
  } samp_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  logic [LOG2N-1:0]         wr_cnt, rd_cnt, wr_addr;
  logic                     wr_bank, rd_bank;
  logic [NBANKS-1:0]        bank_full, bank_wr, bank_rd_close;
  samp_t [NBANKS-1:0]       bank_q;
  samp_t                    wr_data, rd_data;
  logic                     accept, load, wr_close, rd_close;

  assign bus.in_ready = !bank_full[wr_bank];
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = (!bus.out_valid || bus.out_ready) && bank_full[rd_bank];
  assign wr_close     = accept && (wr_cnt == LAST_IDX);
  assign rd_close     = load && (rd_cnt == LAST_IDX);
  assign wr_addr      = bitrev(wr_cnt);
  assign wr_data      = '{re: bus.in_re, im: bus.in_im};
  assign rd_data      = bank_q[rd_bank];

  generate
    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      assign bank_wr[b]       = accept && (wr_bank == 1'(b));
      assign bank_rd_close[b] = rd_close && (rd_bank == 1'(b));

      fft_bitrev_bank #(.DW(2*NBITS), .LOG2N(LOG2N)) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (bank_wr[b]),
        .wr_close (wr_close),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_close (bank_rd_close[b]),
        .rd_addr  (rd_cnt),
        .rd_data  (bank_q[b]),
        .full     (bank_full[b])
      );
    end
  endgenerate

  // Frames close on the sample count; in_last is only cross-checked against it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt        <= '0;
      wr_bank       <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= accept && (bus.in_last != (wr_cnt == LAST_IDX));
      if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_close) wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt        <= '0;
      rd_bank       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_re    <= '0;
      bus.out_im    <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_re    <= rd_data.re;
      bus.out_im    <= rd_data.im;
      bus.out_index <= rd_cnt;
      bus.out_last  <= (rd_cnt == LAST_IDX);
      rd_cnt        <= rd_cnt + 1'b1;
      if (rd_close) rd_bank <= ~rd_bank;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Bench for fft_bitrev_reader: directed frame sequences with random data and handshakes,
// compared every cycle against a queue-based model of the reorder buffer.
module tb_fft_bitrev_reader;
  localparam int NBITS   = 16;
  localparam int NPOINTS = 16;
  localparam int LOG2N   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fft_bitrev_reader_if #(.NBITS(NBITS), .LOG2N(LOG2N)) bus();

  fft_bitrev_reader #(.NBITS(NBITS), .NPOINTS(NPOINTS), .LOG2N(LOG2N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: frames in natural order waiting to be read, plus the frame being collected.
  logic [31:0] q_nat[$];
  logic [31:0] cur_in[$];
  int          rd_pos;
  logic        ev, elast, eferr;
  logic [15:0] ere, eim;
  logic [3:0]  eidx;

  logic        t1_log = 1'b0;
  logic [15:0] t1_re[$];
  logic [15:0] t1_exp [16] = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14,
                               16'd1, 16'd9, 16'd5, 16'd13, 16'd3, 16'd11, 16'd7, 16'd15};

  function automatic int brev(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < LOG2N; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic pick_ready(input int omode);
    if (omode == 0) return 1'b0;
    if (omode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] re, input logic [15:0] im,
                      input logic last, input logic ordy, input logic rst, output logic acc);
    logic ir_exp, load;
    int pend;
    bus.in_valid  = v;
    bus.in_re     = re;
    bus.in_im     = im;
    bus.in_last   = last;
    bus.out_ready = ordy;
    rst_n         = ~rst;
    pend   = (q_nat.size() + NPOINTS - 1) / NPOINTS;
    ir_exp = (pend < 2);
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, ir_exp});
    acc = 1'b0;
    @(posedge clk);
    if (rst) begin
      q_nat.delete(); cur_in.delete();
      rd_pos = 0; ev = 0; ere = 0; eim = 0; eidx = 0; elast = 0; eferr = 0;
    end else begin
      acc  = v && ir_exp;
      load = (!ev || ordy) && (pend > 0);
      if (load) begin
        {ere, eim} = q_nat.pop_front();
        eidx   = 4'(rd_pos);
        elast  = (rd_pos == NPOINTS - 1);
        ev     = 1'b1;
        rd_pos = (rd_pos + 1) % NPOINTS;
      end else if (ordy) begin
        ev = 1'b0;
      end
      eferr = 1'b0;
      if (acc) begin
        cur_in.push_back({re, im});
        eferr = (last != (cur_in.size() == NPOINTS));
        if (cur_in.size() == NPOINTS) begin
          for (int b = 0; b < NPOINTS; b++) q_nat.push_back(cur_in[brev(b)]);
          cur_in.delete();
        end
      end
    end
    #1;
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, ev});
    chk("out_re",    {16'b0, bus.out_re},    {16'b0, ere});
    chk("out_im",    {16'b0, bus.out_im},    {16'b0, eim});
    chk("out_index", {28'b0, bus.out_index}, {28'b0, eidx});
    chk("out_last",  {31'b0, bus.out_last},  {31'b0, elast});
    chk("frame_err", {31'b0, bus.frame_err}, {31'b0, eferr});
    if (t1_log && bus.out_valid) t1_re.push_back(bus.out_re);
  endtask

  // Sends nfr frames; last_at<0 marks in_last on sample 15, otherwise on sample last_at only.
  task automatic send_frames(input int nfr, input int omode, input int dmode,
                             input int last_at, input int vmode);
    int k = 0;
    int guard = 0;
    int kk;
    logic acc, last, v;
    logic [15:0] re, im;
    re = dmode ? 16'($urandom) : 16'd0;
    im = dmode ? 16'($urandom) : 16'd0;
    while (k < nfr * NPOINTS && guard < 4000) begin
      kk   = k % NPOINTS;
      last = (last_at < 0) ? (kk == NPOINTS - 1) : (kk == last_at);
      v    = vmode ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(v, re, im, last, pick_ready(omode), 1'b0, acc);
      if (acc) begin
        k++;
        kk = k % NPOINTS;
        re = dmode ? 16'($urandom) : 16'(kk);
        im = dmode ? 16'($urandom) : 16'(-kk);
      end
      guard++;
    end
    chk("send_done", k, nfr * NPOINTS);
  endtask

  task automatic drain(input int n, input int omode);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 16'd0, 16'd0, 1'b0, pick_ready(omode), 1'b0, acc);
  endtask

  initial begin
    logic acc;
    bus.in_valid = 0; bus.in_re = 0; bus.in_im = 0; bus.in_last = 0; bus.out_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, acc);

    // 1: ramp frame, natural-order readout and latency
    t1_log = 1'b1;
    send_frames(1, 1, 0, -1, 0);
    chk("t1_lat_edge1", {31'b0, bus.out_valid}, 32'd0);
    drain(1, 1);
    chk("t1_lat_edge2", {31'b0, bus.out_valid}, 32'd1);
    drain(20, 1);
    t1_log = 1'b0;
    chk("t1_count", t1_re.size(), 16);
    for (int i = 0; i < 16 && i < t1_re.size(); i++) chk("t1_re_seq", {16'b0, t1_re[i]}, {16'b0, t1_exp[i]});

    // 2: three back-to-back frames, downstream always ready
    send_frames(3, 1, 1, -1, 0);
    drain(20, 1);

    // 3: two frames with downstream stalled, then release
    send_frames(2, 0, 1, -1, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, acc);
    chk("t3_stalled", {31'b0, bus.in_ready}, 32'd0);
    send_frames(1, 1, 1, -1, 0);
    drain(40, 1);

    // 4: random backpressure and bursty input
    send_frames(2, 2, 1, -1, 1);
    drain(60, 2);
    drain(20, 1);

    // 5: early in_last, then missing in_last
    send_frames(1, 1, 0, 9, 0);
    send_frames(1, 1, 0, 99, 0);
    drain(20, 1);

    // 6: reset after a partial frame, then a fresh frame
    for (int i = 0; i < 7; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, acc);
    send_frames(1, 1, 1, -1, 0);
    drain(20, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
